// File: rtl/mult_arbiter.sv
// Two-requester round-robin front end for a times-table memory of configurable read latency.
// Accepts one operation per RD_LAT+2 cycles and returns the table word tagged with its requester id.
module mult_arbiter #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [2:0] req0_a,
  input  logic [2:0] req0_b,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [2:0] req1_a,
  input  logic [2:0] req1_b,
  output logic       req1_ready,
  output logic       tbl_en,
  output logic [2:0] tbl_a,
  output logic [2:0] tbl_b,
  input  logic [5:0] tbl_result,
  output logic       resp_valid,
  output logic       resp_id,
  output logic [5:0] resp_result,
  output logic       busy
);

  localparam int unsigned CW = 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          prio;
  logic          owner;
  logic          idle_c;
  logic          grant0_c;
  logic          grant1_c;

  // Grant is combinational in IDLE so the table read starts in the accept cycle itself.
  always_comb begin
    idle_c   = (state == IDLE) && !rst;
    grant0_c = idle_c && req0_valid && (!req1_valid || !prio);
    grant1_c = idle_c && req1_valid && (!req0_valid || prio);
  end

  assign req0_ready = grant0_c;
  assign req1_ready = grant1_c;
  assign tbl_en     = grant0_c | grant1_c;
  assign tbl_a      = grant0_c ? req0_a : (grant1_c ? req1_a : 3'd0);
  assign tbl_b      = grant0_c ? req0_b : (grant1_c ? req1_b : 3'd0);

  // resp_id is only updated with the strobe; owner carries the id while the read is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      prio        <= 1'b0;
      owner       <= 1'b0;
      resp_valid  <= 1'b0;
      resp_id     <= 1'b0;
      resp_result <= 6'd0;
      busy        <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant0_c || grant1_c) begin
            state <= WAIT;
            cnt   <= CW'(RD_LAT - 1);
            owner <= grant1_c;
            prio  <= grant0_c;
            busy  <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            resp_result <= tbl_result;
            resp_id     <= owner;
            resp_valid  <= 1'b1;
            state       <= RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Randomized and directed bench for mult_arbiter: a cycle-level reference model predicts grants,
// table accesses and responses; a scoreboard queue feeds a separate response monitor.
module tb_mult_arbiter;

  localparam int unsigned LAT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [2:0] req0_a = 3'd0, req0_b = 3'd0, req1_a = 3'd0, req1_b = 3'd0;
  logic       req0_ready, req1_ready, tbl_en, resp_valid, resp_id, busy;
  logic [2:0] tbl_a, tbl_b;
  logic [5:0] tbl_result, resp_result;

  always #5 clk = ~clk;

  mult_arbiter #(.RD_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .tbl_en(tbl_en), .tbl_a(tbl_a), .tbl_b(tbl_b), .tbl_result(tbl_result),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_result(resp_result), .busy(busy)
  );

  // Times-table memory: data appears LAT cycles after the enable, garbage otherwise.
  logic [5:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= tbl_en ? 6'(int'(tbl_a) * int'(tbl_b)) : 6'($urandom_range(63));
    for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
  end
  assign tbl_result = pipe[LAT-1];

  typedef struct {
    logic       id;
    logic [5:0] res;
    int         due;
  } exp_t;

  exp_t       q[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         next_free = 0;
  logic       prio = 1'b0;
  logic       last_id = 1'b0;
  logic [5:0] last_res = 6'd0;
  int         grants = 0;

  logic       p0v = 1'b0, p1v = 1'b0;
  logic [2:0] p0a = 3'd0, p0b = 3'd0, p1a = 3'd0, p1b = 3'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0 && q[0].due < cyc) begin
      chk("resp_late", cyc, q[0].due);
      void'(q.pop_front());
    end
    if (resp_valid) begin
      if (q.size() == 0) begin
        chk("spurious_resp", int'(resp_valid), 0);
      end else begin
        e = q.pop_front();
        chk("resp_cycle", cyc, e.due);
        chk("resp_id", int'(resp_id), int'(e.id));
        chk("resp_result", int'(resp_result), int'(e.res));
        last_id  = e.id;
        last_res = e.res;
      end
    end else begin
      chk("hold_result", int'(resp_result), int'(last_res));
      chk("hold_id", int'(resp_id), int'(last_id));
    end
  end

  // One clock cycle: present the pending requests, then check grant and table outputs.
  task automatic step();
    logic idle, e0, e1;
    @(negedge clk);
    req0_valid = p0v; req0_a = p0a; req0_b = p0b;
    req1_valid = p1v; req1_a = p1a; req1_b = p1b;
    #1;
    idle = !rst && (cyc >= next_free);
    e0   = idle && p0v && (!p1v || !prio);
    e1   = idle && p1v && (!p0v || prio);
    chk("req0_ready", int'(req0_ready), int'(e0));
    chk("req1_ready", int'(req1_ready), int'(e1));
    chk("tbl_en", int'(tbl_en), int'(e0 | e1));
    chk("tbl_a", int'(tbl_a), e0 ? int'(p0a) : (e1 ? int'(p1a) : 0));
    chk("tbl_b", int'(tbl_b), e0 ? int'(p0b) : (e1 ? int'(p1b) : 0));
    chk("busy", int'(busy), int'(!rst && cyc < next_free));
    if (e0 || e1) begin
      q.push_back('{id: e1,
                    res: e0 ? 6'(int'(p0a) * int'(p0b)) : 6'(int'(p1a) * int'(p1b)),
                    due: cyc + int'(LAT) + 1});
      prio      = e0;
      next_free = cyc + int'(LAT) + 2;
      grants++;
      if (e0) p0v = 1'b0;
      else    p1v = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_resp_valid", int'(resp_valid), 0);
    chk("rst_resp_id", int'(resp_id), 0);
    chk("rst_resp_result", int'(resp_result), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_tbl_en", int'(tbl_en), 0);
    chk("rst_req0_ready", int'(req0_ready), 0);
    chk("rst_req1_ready", int'(req1_ready), 0);
    q.delete();
    last_id   = 1'b0;
    last_res  = 6'd0;
    prio      = 1'b0;
    next_free = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((p0v || p1v) && n < 50) begin
      step();
      n++;
    end
    chk("grant_timeout", int'(p0v) + int'(p1v), 0);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Both requesters valid in the first cycle after reset: req0 wins, then req1.
    p0v = 1'b1; p0a = 3'd7; p0b = 3'd7;
    p1v = 1'b1; p1a = 3'd2; p1b = 3'd3;
    drain();
    idle_steps(int'(LAT) + 3);

    // Lone requester 0, 3x5.
    p0v = 1'b1; p0a = 3'd3; p0b = 3'd5;
    drain();
    idle_steps(int'(LAT) + 3);

    // Requester 1, 0x6: zero result then held.
    p1v = 1'b1; p1a = 3'd0; p1b = 3'd6;
    drain();
    idle_steps(int'(LAT) + 5);

    // Eight back-to-back operations with both requesters continuously valid.
    grants = 0;
    while (grants < 8 && cyc < 2000) begin
      if (!p0v) begin p0v = 1'b1; p0a = 3'($urandom_range(7)); p0b = 3'($urandom_range(7)); end
      if (!p1v) begin p1v = 1'b1; p1a = 3'($urandom_range(7)); p1b = 3'($urandom_range(7)); end
      step();
    end
    chk("alternation_grants", grants, 8);
    p0v = 1'b0; p1v = 1'b0;
    idle_steps(int'(LAT) + 3);

    // Reset while waiting on req0 4x4: the response is discarded, req0 wins next.
    p0v = 1'b1; p0a = 3'd4; p0b = 3'd4;
    step();
    step();
    do_reset();
    p0v = 1'b1; p0a = 3'd1; p0b = 3'd6;
    p1v = 1'b1; p1a = 3'd5; p1b = 3'd5;
    drain();
    idle_steps(int'(LAT) + 3);

    // req0 pulsed during WAIT and withdrawn before IDLE: no table access.
    p1v = 1'b1; p1a = 3'd2; p1b = 3'd2;
    step();
    p0v = 1'b1; p0a = 3'd6; p0b = 3'd6;
    step();
    p0v = 1'b0;
    idle_steps(int'(LAT) + 3);

    // Randomized traffic; requests may be withdrawn only while the block is busy.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      if (!p0v && $urandom_range(2) == 0) begin
        p0v = 1'b1; p0a = 3'($urandom_range(7)); p0b = 3'($urandom_range(7));
      end else if (p0v && (cyc + 1 < next_free) && $urandom_range(7) == 0) begin
        p0v = 1'b0;
      end
      if (!p1v && $urandom_range(2) == 0) begin
        p1v = 1'b1; p1a = 3'($urandom_range(7)); p1b = 3'($urandom_range(7));
      end else if (p1v && (cyc + 1 < next_free) && $urandom_range(7) == 0) begin
        p1v = 1'b0;
      end
      step();
    end
    drain();
    idle_steps(int'(LAT) + 4);
    chk("queue_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 The block SHALL have parameter RD_LAT, default 1: read latency of the times-table memory in cycles, legal range 1..3.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have ports req0_valid and req1_valid, input, 1 bit each: requester n presents an operation.
REQ-005 The block SHALL have ports req0_a, req0_b, req1_a and req1_b, input, 3 bits each: operands of requester n.
REQ-006 The block SHALL have ports req0_ready and req1_ready, output, 1 bit each: requester n's operation is accepted this cycle.
REQ-007 The block SHALL have port tbl_en, output, 1 bit: table read enable.
REQ-008 The block SHALL have ports tbl_a and tbl_b, output, 3 bits each: table address halves (address = {a,b}).
REQ-009 The block SHALL have port tbl_result, input, 6 bits: table read data, valid RD_LAT cycles after tbl_en.
REQ-010 The block SHALL have port resp_valid, output, 1 bit: one-cycle result strobe.
REQ-011 The block SHALL have port resp_id, output, 1 bit: requester owning the current result.
REQ-012 The block SHALL have port resp_result, output, 6 bits: product a*b, 0..49.
REQ-013 The block SHALL have port busy, output, 1 bit: asserted when state is not IDLE.

Function
REQ-014 The block SHALL implement states IDLE, WAIT and RESP.
REQ-015 In IDLE with at least one reqN_valid high, the block SHALL assert exactly one reqN_ready combinationally, the grant.
REQ-016 The cycle in which a grant is given SHALL be the accept cycle N; in N the block SHALL drive tbl_en=1 and tbl_a/tbl_b from the granted requester's operands.
REQ-017 On the edge ending cycle N, the block SHALL latch the granted id and move to WAIT.
REQ-018 In WAIT, a down-counter loaded with RD_LAT-1 SHALL decrement each cycle; at zero, the block SHALL register tbl_result into resp_result and go to RESP.
REQ-019 In RESP (cycle N+RD_LAT+1), the block SHALL drive resp_valid=1 for exactly one cycle with the latched resp_id, then return to IDLE.
REQ-020 The block SHALL NOT accept a new operation in WAIT or RESP; peak throughput SHALL be one operation per RD_LAT+2 cycles.
REQ-021 Round-robin: when both requesters are valid in IDLE, the block SHALL grant the priority holder; after any grant, priority SHALL pass to the other requester.
REQ-022 A single valid requester SHALL be granted regardless of priority.
REQ-023 Requesters SHALL hold valid and operands stable until ready; a valid that drops before ready SHALL cause no table access.
REQ-024 Outside the accept cycle, tbl_en, tbl_a and tbl_b SHALL be 0.
REQ-025 resp_result and resp_id SHALL hold their last values between strobes.
REQ-026 Width rule: the block SHALL pass tbl_result through unmodified, with no arithmetic on the data path.

Reset
REQ-027 When rst is high, the block SHALL, asynchronously: set state to IDLE; set the counter to 0; give priority to requester 0; and drive resp_valid=0, resp_id=0, resp_result=0, busy=0, tbl_en=0 and both ready outputs to 0.
REQ-028 An operation in flight when rst asserts SHALL be discarded; no resp_valid SHALL follow reset.
REQ-029 The first grant after reset deassertion SHALL be evaluated in the first IDLE cycle with rst low.

Verification
REQ-030 With RD_LAT=1, req0 3x5 alone -> req0_ready and tbl_en high in cycle N, tbl_a=3, tbl_b=5, resp_valid in N+2, resp_id=0, resp_result=15, busy high in N+1..N+2.
REQ-031 Both valid in the first cycle after reset, req0 7x7 and req1 2x3 -> req0 granted first (resp 49, id 0), then req1 granted in the next IDLE (resp 6, id 1).
REQ-032 Both held valid for 8 consecutive operations -> grants alternate 0,1,0,1,..., with one accept every RD_LAT+2 cycles and no ready asserted in WAIT or RESP.
REQ-033 With RD_LAT=3, req1 0x6 -> resp_valid 4 cycles after accept with resp_result=0; resp_result holds 0 afterwards.
REQ-034 rst pulsed while in WAIT after accepting req0 4x4 -> no resp_valid at any later cycle; outputs read 0 immediately; the next dual request grants req0.
REQ-035 req0_valid pulsed high while state is WAIT and then dropped before IDLE -> no grant, tbl_en stays 0.
